// File: rtl/reorder_buffer_pkg.sv
// Shared types and constants for the reorder buffer: default sizing, exception encoding and the
// per-entry payload record.
package reorder_buffer_pkg;

  localparam int unsigned ROB_ADDR_WIDTH_DEFAULT = 4;
  localparam int unsigned EXC_TYPE_WIDTH = 5;

  typedef logic [EXC_TYPE_WIDTH-1:0] exc_type_t;

  localparam exc_type_t EXC_TYPE_NULL = '0;

  typedef struct packed {
    logic        reg_write_en;
    logic [4:0]  reg_write_addr;
    exc_type_t   exception_type;
    logic        is_delayslot;
    logic [31:0] pc;
    logic [31:0] data;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// Reorder buffer port bundle: allocation, writeback, commit and operand lookup.
// The master drives requests; the slave is the buffer itself.
interface reorder_buffer_if
  import reorder_buffer_pkg::*;
#(
  parameter int unsigned ROB_ADDR_WIDTH = ROB_ADDR_WIDTH_DEFAULT
);

  logic                      flush;

  logic                      rob_write_en;
  logic                      rob_can_write;
  logic [ROB_ADDR_WIDTH-1:0] rob_write_addr;
  logic                      rob_write_reg_write_en;
  logic [4:0]                rob_write_reg_write_addr;
  exc_type_t                 rob_write_exception_type;
  logic                      rob_write_is_delayslot;
  logic [31:0]               rob_write_pc;

  logic                      wb_en;
  logic [ROB_ADDR_WIDTH-1:0] wb_addr;
  logic [31:0]               wb_data;
  exc_type_t                 wb_exception_type;

  logic                      rob_commit_en;
  logic                      rob_can_commit;
  logic                      rob_commit_reg_write_en;
  logic [4:0]                rob_commit_reg_write_addr;
  logic [31:0]               rob_commit_reg_write_data;
  exc_type_t                 rob_commit_exception_type;
  logic                      rob_commit_is_delayslot;
  logic [31:0]               rob_commit_pc;

  logic [ROB_ADDR_WIDTH-1:0] read_addr;
  logic                      read_done;
  logic [31:0]               read_data;

  modport master (
    output flush,
    output rob_write_en, rob_write_reg_write_en, rob_write_reg_write_addr,
    output rob_write_exception_type, rob_write_is_delayslot, rob_write_pc,
    input  rob_can_write, rob_write_addr,
    output wb_en, wb_addr, wb_data, wb_exception_type,
    output rob_commit_en,
    input  rob_can_commit, rob_commit_reg_write_en, rob_commit_reg_write_addr,
    input  rob_commit_reg_write_data, rob_commit_exception_type, rob_commit_is_delayslot,
    input  rob_commit_pc,
    output read_addr,
    input  read_done, read_data
  );

  modport slave (
    input  flush,
    input  rob_write_en, rob_write_reg_write_en, rob_write_reg_write_addr,
    input  rob_write_exception_type, rob_write_is_delayslot, rob_write_pc,
    output rob_can_write, rob_write_addr,
    input  wb_en, wb_addr, wb_data, wb_exception_type,
    input  rob_commit_en,
    output rob_can_commit, rob_commit_reg_write_en, rob_commit_reg_write_addr,
    output rob_commit_reg_write_data, rob_commit_exception_type, rob_commit_is_delayslot,
    output rob_commit_pc,
    input  read_addr,
    output read_done, read_data
  );

endinterface

// File: rtl/rob_ptr.sv
// Wrapping reorder-buffer pointer: index bits plus a wrap bit (MSB), with increment enable and
// synchronous clear. Reset is synchronous, active-low.
module rob_ptr #(
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                inc,
  output logic [ADDR_WIDTH:0] ptr
);

  logic [ADDR_WIDTH:0] ptr_q;

  // Natural overflow of the extra bit toggles wrap with no bubble.
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      ptr_q <= '0;
    end else if (inc) begin
      ptr_q <= ptr_q + 1'b1;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/reorder_buffer.sv
// In-order reorder buffer: allocates at the tail, accepts out-of-order result writeback and
// retires done entries from the head. Reset is synchronous, active-low; flush empties the buffer.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int unsigned ROB_ADDR_WIDTH = ROB_ADDR_WIDTH_DEFAULT
) (
  input logic             clk,
  input logic             rst,
  reorder_buffer_if.slave rob
);

  localparam int unsigned Depth = 2 ** ROB_ADDR_WIDTH;

  logic [ROB_ADDR_WIDTH:0]   head;
  logic [ROB_ADDR_WIDTH:0]   tail;
  logic [ROB_ADDR_WIDTH-1:0] head_idx;
  logic [ROB_ADDR_WIDTH-1:0] tail_idx;

  logic [Depth-1:0] valid_q;
  logic [Depth-1:0] done_q;
  rob_entry_t       entry_q [Depth];

  logic empty;
  logic full;
  logic commit_ok;
  logic do_write;
  logic do_commit;
  logic wb_hit;

  assign head_idx = head[ROB_ADDR_WIDTH-1:0];
  assign tail_idx = tail[ROB_ADDR_WIDTH-1:0];

  assign empty     = (head == tail);
  assign full      = (head_idx == tail_idx) && (head[ROB_ADDR_WIDTH] != tail[ROB_ADDR_WIDTH]);
  assign commit_ok = !empty && done_q[head_idx];

  // All handshakes use registered occupancy only; a same-cycle commit never frees a write slot.
  assign do_write  = rob.rob_write_en && !full;
  assign do_commit = rob.rob_commit_en && commit_ok;
  assign wb_hit    = rob.wb_en && valid_q[rob.wb_addr];

  rob_ptr #(
    .ADDR_WIDTH(ROB_ADDR_WIDTH)
  ) u_head_ptr (
    .clk(clk),
    .rst(rst),
    .clr(rob.flush),
    .inc(do_commit),
    .ptr(head)
  );

  rob_ptr #(
    .ADDR_WIDTH(ROB_ADDR_WIDTH)
  ) u_tail_ptr (
    .clk(clk),
    .rst(rst),
    .clr(rob.flush),
    .inc(do_write),
    .ptr(tail)
  );

  // Allocation is applied last so it wins over a writeback to the same index.
  always_ff @(posedge clk) begin
    if (!rst || rob.flush) begin
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      if (wb_hit) begin
        done_q[rob.wb_addr] <= 1'b1;
      end
      if (do_commit) begin
        valid_q[head_idx] <= 1'b0;
      end
      if (do_write) begin
        valid_q[tail_idx] <= 1'b1;
        done_q[tail_idx]  <= (rob.rob_write_exception_type != EXC_TYPE_NULL);
      end
    end
  end

  // Payload carries no reset; it is only observed through valid/done.
  always_ff @(posedge clk) begin
    if (wb_hit) begin
      entry_q[rob.wb_addr].data <= rob.wb_data;
      if (rob.wb_exception_type != EXC_TYPE_NULL) begin
        entry_q[rob.wb_addr].exception_type <= rob.wb_exception_type;
      end
    end
    if (do_write) begin
      entry_q[tail_idx] <= '{
        reg_write_en:   rob.rob_write_reg_write_en,
        reg_write_addr: rob.rob_write_reg_write_addr,
        exception_type: rob.rob_write_exception_type,
        is_delayslot:   rob.rob_write_is_delayslot,
        pc:             rob.rob_write_pc,
        data:           32'h0
      };
    end
  end

  assign rob.rob_can_write  = rst && !full;
  assign rob.rob_write_addr = tail_idx;
  assign rob.rob_can_commit = rst && commit_ok;

  assign rob.rob_commit_reg_write_en   = entry_q[head_idx].reg_write_en;
  assign rob.rob_commit_reg_write_addr = entry_q[head_idx].reg_write_addr;
  assign rob.rob_commit_reg_write_data = entry_q[head_idx].data;
  assign rob.rob_commit_exception_type = entry_q[head_idx].exception_type;
  assign rob.rob_commit_is_delayslot   = entry_q[head_idx].is_delayslot;
  assign rob.rob_commit_pc             = entry_q[head_idx].pc;

  assign rob.read_done = valid_q[rob.read_addr] && done_q[rob.read_addr];
  assign rob.read_data = entry_q[rob.read_addr].data;

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: a scoreboard queue of allocated entries is popped on
// every commit, with per-index expected done/data/exception state kept alongside.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  typedef struct {
    logic [31:0] pc;
    logic        ds;
    logic        rwe;
    logic [4:0]  rwa;
  } sb_t;

  logic clk;
  logic rst;

  reorder_buffer_if #(.ROB_ADDR_WIDTH(4)) rob ();

  reorder_buffer #(.ROB_ADDR_WIDTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .rob(rob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp;
  int unsigned n_err;

  sb_t         sb[$];
  logic [4:0]  hd;
  logic [4:0]  tl;
  int          cnt;
  logic [15:0] mvalid;
  logic [15:0] mdone;
  logic [15:0] mwb;
  logic [31:0] md   [16];
  exc_type_t   mexc [16];
  logic [31:0] pcv;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rob.flush                    = 1'b0;
    rob.rob_write_en             = 1'b0;
    rob.rob_write_reg_write_en   = 1'b0;
    rob.rob_write_reg_write_addr = '0;
    rob.rob_write_exception_type = EXC_TYPE_NULL;
    rob.rob_write_is_delayslot   = 1'b0;
    rob.rob_write_pc             = '0;
    rob.wb_en                    = 1'b0;
    rob.wb_addr                  = '0;
    rob.wb_data                  = '0;
    rob.wb_exception_type        = EXC_TYPE_NULL;
    rob.rob_commit_en            = 1'b0;
    rob.read_addr                = '0;
  endtask

  task automatic model_clear();
    hd = '0; tl = '0; cnt = 0;
    mvalid = '0; mdone = '0; mwb = '0;
    sb.delete();
  endtask

  task automatic check_all_read_clear(input string tag);
    for (int i = 0; i < 16; i++) begin
      rob.read_addr = 4'(i);
      #1;
      check(tag, {31'b0, rob.read_done}, 32'd0);
    end
    rob.read_addr = '0;
  endtask

  // One clock cycle: drive, check pre-edge outputs against the model, update the model, clock.
  task automatic step(input logic we, input exc_type_t exc, input logic wbe,
                      input logic [3:0] wba, input logic [31:0] wbd, input exc_type_t wbx,
                      input logic ce, input logic fl);
    logic [3:0] h;
    logic [3:0] t;
    logic       exp_cw;
    logic       exp_cc;
    sb_t        e;
    h = hd[3:0];
    t = tl[3:0];
    rob.rob_write_en             = we;
    rob.rob_write_pc             = pcv;
    rob.rob_write_is_delayslot   = pcv[3];
    rob.rob_write_reg_write_en   = pcv[2];
    rob.rob_write_reg_write_addr = pcv[8:4];
    rob.rob_write_exception_type = exc;
    rob.wb_en                    = wbe;
    rob.wb_addr                  = wba;
    rob.wb_data                  = wbd;
    rob.wb_exception_type        = wbx;
    rob.rob_commit_en            = ce;
    rob.flush                    = fl;
    #1;
    exp_cw = (cnt < 16);
    exp_cc = (cnt > 0) && mdone[h];
    check("can_write", {31'b0, rob.rob_can_write}, {31'b0, exp_cw});
    check("write_addr", {28'b0, rob.rob_write_addr}, {28'b0, t});
    check("can_commit", {31'b0, rob.rob_can_commit}, {31'b0, exp_cc});
    if (exp_cc) begin
      e = sb[0];
      check("commit_pc", rob.rob_commit_pc, e.pc);
      check("commit_ds", {31'b0, rob.rob_commit_is_delayslot}, {31'b0, e.ds});
      check("commit_rwe", {31'b0, rob.rob_commit_reg_write_en}, {31'b0, e.rwe});
      check("commit_rwa", {27'b0, rob.rob_commit_reg_write_addr}, {27'b0, e.rwa});
      check("commit_exc", {27'b0, rob.rob_commit_exception_type}, {27'b0, mexc[h]});
      if (mwb[h]) check("commit_data", rob.rob_commit_reg_write_data, md[h]);
    end
    if (fl) begin
      model_clear();
    end else begin
      if (wbe && mvalid[wba]) begin
        mdone[wba] = 1'b1;
        mwb[wba]   = 1'b1;
        md[wba]    = wbd;
        if (wbx != EXC_TYPE_NULL) mexc[wba] = wbx;
      end
      if (ce && exp_cc) begin
        void'(sb.pop_front());
        mvalid[h] = 1'b0;
        hd = hd + 5'd1;
        cnt--;
      end
      if (we && exp_cw) begin
        sb.push_back('{pc: pcv, ds: pcv[3], rwe: pcv[2], rwa: pcv[8:4]});
        mvalid[t] = 1'b1;
        mdone[t]  = (exc != EXC_TYPE_NULL);
        mwb[t]    = 1'b0;
        mexc[t]   = exc;
        tl = tl + 5'd1;
        cnt++;
      end
    end
    if (we) pcv = pcv + 32'd4;
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic alloc(input exc_type_t exc);
    step(1'b1, exc, 1'b0, 4'd0, 32'd0, EXC_TYPE_NULL, 1'b0, 1'b0);
  endtask

  task automatic wb(input logic [3:0] a, input logic [31:0] d, input exc_type_t x);
    step(1'b0, EXC_TYPE_NULL, 1'b1, a, d, x, 1'b0, 1'b0);
  endtask

  task automatic commit();
    step(1'b0, EXC_TYPE_NULL, 1'b0, 4'd0, 32'd0, EXC_TYPE_NULL, 1'b1, 1'b0);
  endtask

  // Finish outstanding entries by writeback, then retire everything in order.
  task automatic drain();
    for (int i = 0; i < 16; i++) begin
      if (mvalid[i] && !mdone[i]) wb(4'(i), 32'hD000_0000 + 32'(i), EXC_TYPE_NULL);
    end
    for (int k = 0; k < 16; k++) begin
      if (cnt > 0) commit();
    end
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_can_write", {31'b0, rob.rob_can_write}, 32'd0);
    check("rst_can_commit", {31'b0, rob.rob_can_commit}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    model_clear();
    check("post_rst_can_write", {31'b0, rob.rob_can_write}, 32'd1);
    check("post_rst_write_addr", {28'b0, rob.rob_write_addr}, 32'd0);
    check("post_rst_can_commit", {31'b0, rob.rob_can_commit}, 32'd0);
    check_all_read_clear("post_rst_read_done");
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    pcv   = 32'h100;
    for (int i = 0; i < 16; i++) begin
      md[i]   = '0;
      mexc[i] = EXC_TYPE_NULL;
    end
    do_reset();

    // Fill: tail indices 0..15, then full; a 17th write is dropped.
    for (int i = 0; i < 16; i++) alloc(EXC_TYPE_NULL);
    check("full_can_write", {31'b0, rob.rob_can_write}, 32'd0);
    alloc(EXC_TYPE_NULL);
    check("full_tail_held", {28'b0, rob.rob_write_addr}, 32'd0);
    drain();

    // Out-of-order writeback: head waits for index 0.
    do_reset();
    for (int i = 0; i < 3; i++) alloc(EXC_TYPE_NULL);
    wb(4'd1, 32'h11, EXC_TYPE_NULL);
    wb(4'd0, 32'hA5, EXC_TYPE_NULL);
    rob.read_addr = 4'd0;
    #1;
    check("read_done_0", {31'b0, rob.read_done}, 32'd1);
    check("read_data_0", rob.read_data, 32'hA5);
    rob.read_addr = 4'd2;
    #1;
    check("read_done_2", {31'b0, rob.read_done}, 32'd0);
    commit();
    commit();
    commit();
    wb(4'd2, 32'h22, 5'd7);
    commit();

    // Exception at allocation: committable next cycle without writeback.
    alloc(5'd5);
    commit();

    // Full with done head: simultaneous write is rejected, commit retires.
    alloc(5'd9);
    for (int i = 0; i < 15; i++) alloc(EXC_TYPE_NULL);
    step(1'b1, EXC_TYPE_NULL, 1'b0, 4'd0, 32'd0, EXC_TYPE_NULL, 1'b1, 1'b0);
    check("after_pair_can_write", {31'b0, rob.rob_can_write}, 32'd1);
    drain();

    // Pointer wrap from index 14.
    do_reset();
    for (int i = 0; i < 14; i++) begin
      alloc(5'd3);
      commit();
    end
    for (int i = 0; i < 4; i++) begin
      alloc(5'd3);
      commit();
    end
    check("wrap_tail", {28'b0, rob.rob_write_addr}, 32'd2);
    check("wrap_empty", {31'b0, rob.rob_can_commit}, 32'd0);
    alloc(5'd4);
    for (int i = 0; i < 3; i++) step(1'b1, 5'd4, 1'b0, 4'd0, 32'd0, EXC_TYPE_NULL, 1'b1, 1'b0);
    drain();

    // Flush with 5 entries and concurrent write/writeback/commit.
    for (int i = 0; i < 5; i++) alloc(EXC_TYPE_NULL);
    wb(hd[3:0], 32'h77, EXC_TYPE_NULL);
    step(1'b1, 5'd2, 1'b1, tl[3:0] - 4'd1, 32'h55, EXC_TYPE_NULL, 1'b1, 1'b1);
    check("flush_write_addr", {28'b0, rob.rob_write_addr}, 32'd0);
    check("flush_can_commit", {31'b0, rob.rob_can_commit}, 32'd0);
    check_all_read_clear("flush_read_done");

    // Reset mid-operation with commit requested: nothing retires.
    for (int i = 0; i < 3; i++) alloc(5'd6);
    rob.rob_commit_en = 1'b1;
    rst = 1'b0;
    #1;
    check("midrst_can_commit", {31'b0, rob.rob_can_commit}, 32'd0);
    check("midrst_can_write", {31'b0, rob.rob_can_write}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle();
    #1;
    model_clear();
    check("midrst_write_addr", {28'b0, rob.rob_write_addr}, 32'd0);
    check("midrst_empty", {31'b0, rob.rob_can_commit}, 32'd0);
    check_all_read_clear("midrst_read_done");
    alloc(EXC_TYPE_NULL);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
